// File: rtl/vga_stream_timing_sink.sv
// Pixel-stream sink: buffers {rgb, sof} words in a small FIFO and aligns them to a VGA raster.
// The pixel rate comes from a clock-enable divider on the single system clock.
module vga_stream_timing_sink #(
  parameter int CD         = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int PIX_DIV    = 4,
  parameter int HD         = 640,
  parameter int HF         = 16,
  parameter int HB         = 48,
  parameter int HR         = 96,
  parameter int VD         = 480,
  parameter int VF         = 10,
  parameter int VB         = 33,
  parameter int VR         = 2
) (
  input  logic          clk,
  input  logic          reset_sys,
  input  logic [CD:0]   si_data,
  input  logic          si_valid,
  output logic          si_ready,
  output logic          hsync,
  output logic          vsync,
  output logic [CD-1:0] rgb,
  output logic          locked,
  output logic          underflow
);

  localparam int HT = HD + HF + HB + HR;
  localparam int VT = VD + VF + VB + VR;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  logic [CD:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic [DW-1:0]  r_div;
  logic [HW-1:0]  r_h;
  logic [VW-1:0]  r_v;
  logic [1:0]     r_state;
  logic           r_hsync, r_vsync, r_locked, r_underflow;
  logic [CD-1:0]  r_rgb;

  logic           w_full, w_empty, w_push, w_pop;
  logic           w_tick, w_active, w_origin;
  logic [CD:0]    w_head;
  logic [1:0]     w_state_nxt;
  logic [CD-1:0]  w_rgb_nxt;
  logic           w_under_nxt;

  assign w_full   = (r_count == CW'(FIFO_DEPTH));
  assign w_empty  = (r_count == '0);
  // No full-bypass: a pop in the same cycle does not open the input.
  assign si_ready = reset_sys & ~w_full;
  assign w_push   = si_valid & si_ready;
  assign w_head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= si_data;
  end

  always_ff @(posedge clk or negedge reset_sys) begin
    if (!reset_sys) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  assign w_tick   = (r_div == DW'(PIX_DIV - 1));
  assign w_active = (r_h < HW'(HD)) && (r_v < VW'(VD));
  assign w_origin = (r_h == '0) && (r_v == '0);

  // Raster free-runs from reset, independent of lock state.
  always_ff @(posedge clk or negedge reset_sys) begin
    if (!reset_sys) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        if (r_h == HW'(HT - 1)) begin
          r_h <= '0;
          r_v <= (r_v == VW'(VT - 1)) ? '0 : r_v + VW'(1);
        end else begin
          r_h <= r_h + HW'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_rgb_nxt   = '0;
    w_under_nxt = 1'b0;
    case (r_state)
      ST_SEARCH: begin
        if (!w_empty) begin
          if (w_head[0]) w_state_nxt = ST_WAIT;
          else           w_pop       = 1'b1;
        end
      end
      ST_WAIT: begin
        if (w_tick && w_origin && !w_empty) begin
          w_pop       = 1'b1;
          w_rgb_nxt   = w_head[CD:1];
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        // A sof anywhere but (0,0), or its absence at (0,0), means the stream slipped.
        if (w_tick && w_active) begin
          if (w_empty) begin
            w_under_nxt = 1'b1;
            w_state_nxt = ST_SEARCH;
          end else if (w_origin && !w_head[0]) begin
            w_state_nxt = ST_SEARCH;
          end else if (!w_origin && w_head[0]) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_pop     = 1'b1;
            w_rgb_nxt = w_head[CD:1];
          end
        end
      end
      default: w_state_nxt = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset_sys) begin
    if (!reset_sys) begin
      r_state     <= ST_SEARCH;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_rgb       <= '0;
      r_locked    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_underflow <= w_under_nxt;
      if (w_tick) begin
        r_rgb   <= w_rgb_nxt;
        r_hsync <= !((r_h >= HW'(HD + HF)) && (r_h < HW'(HD + HF + HR)));
        r_vsync <= !((r_v >= VW'(VD + VF)) && (r_v < VW'(VD + VF + VR)));
      end
    end
  end

  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign rgb       = r_rgb;
  assign locked    = r_locked;
  assign underflow = r_underflow;

endmodule

// File: doc/vga_stream_timing_sink.md
Name: vga_stream_timing_sink

Overview:
- Consumer end of the pixel stream that the frame counter and pattern/sprite chain produce.
- Accepts {rgb, start-of-frame} words over a valid/ready handshake and buffers them in a small FIFO.
- Aligns the stream to a 640x480 VGA raster and drives hsync/vsync/rgb.
- Single system clock; pixel rate is derived from it by a clock-enable divider, with no second clock domain.

Parameters:
CD, 12, colour depth (bits of rgb)
FIFO_DEPTH, 16, FIFO entries; power of 2, min 4
PIX_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz)
HD/HF/HB/HR, 640/16/48/96, horizontal display/front porch/back porch/retrace in pixels
VD/VF/VB/VR, 480/10/33/2, vertical display/front porch/back porch/retrace in lines

Ports:
clk  in  1  system clock, all logic on rising edge
reset_sys  in  1  asynchronous, active-low reset
si_data  in  CD+1  bits [CD:1] = rgb, bit [0] = sof (first pixel of frame)
si_valid  in  1  si_data valid
si_ready  out  1  sink can accept a word this cycle
hsync  out  1  horizontal sync, active low
vsync  out  1  vertical sync, active low
rgb  out  CD  pixel colour, 0 outside the display area
locked  out  1  high while the raster is aligned to the stream
underflow  out  1  one-clock pulse when an active pixel finds the FIFO empty

Behaviour:
- Reset (reset_sys low) state:
  - FIFO empty; all counters 0; FSM = SEARCH.
  - hsync = 1, vsync = 1, rgb = 0, locked = 0, underflow = 0.
  - si_ready is forced 0 while reset_sys is low.
- Handshake:
  - si_ready = !fifo_full (combinational).
  - A word is written when si_valid & si_ready.
  - si_data is sampled only on a transfer.
  - Push and pop in the same cycle are legal; the count is unchanged.
  - A full FIFO with a simultaneous pop still shows si_ready = 0 that cycle (no full-bypass).
- Pixel tick:
  - div counter runs 0..PIX_DIV-1 and wraps.
  - tick = (div == PIX_DIV-1).
- Raster counters (advance on tick only):
  - h counts 0..HD+HF+HB+HR-1 (0..799) and wraps; at the wrap, v increments.
  - v counts 0..VD+VF+VB+VR-1 (0..524) and wraps.
  - active = (h < HD) & (v < VD).
  - The raster free-runs regardless of FSM state.
- Sync outputs, registered and updated on tick:
  - hsync = 0 iff HD+HF <= h < HD+HF+HR (656..751).
  - vsync = 0 iff VD+VF <= v < VD+VF+VR (490..491).
  - rgb and sync update on the same clock: one clk after the tick that evaluates that h/v.
- FSM:
  - SEARCH:
    - Each clk with FIFO non-empty: if head.sof = 0, pop and discard (no tick needed); if head.sof = 1, go to WAIT_FRAME without popping.
    - rgb = 0 throughout.
  - WAIT_FRAME:
    - Hold the head.
    - On the tick where h = 0 and v = 0: pop the head, output its rgb, go to LOCKED.
  - LOCKED:
    - On each tick with active = 1: pop the head and output its rgb.
    - If the FIFO is empty on an active tick: rgb = 0, underflow pulses 1 clk, go to SEARCH.
    - If the head has sof = 1 on an active tick other than (0,0): do not pop, rgb = 0, go to WAIT_FRAME.
    - If the head has sof = 0 at the (0,0) tick: rgb = 0, go to SEARCH.
    - On non-active ticks: no pop, rgb = 0.
- locked = (state == LOCKED), registered.
- Reset mid-frame: everything returns to reset values immediately (asynchronous); a word in flight is dropped.

Test Plan:
1. Reset release with no input: hsync period = 800*4 = 3200 clk, low for 96*4 = 384 clk; vsync low for 2 lines (6400 clk); rgb = 0, locked = 0.
2. Continuous frames with sof on pixel 0, rgb = {v[3:0], h[7:0]}, source always valid: locked rises at the first (0,0) tick; every displayed pixel rgb equals the expected pattern; underflow never asserts.
3. Start the stream mid-frame (first word sof = 0, e.g. 1000 junk pixels, then sof = 1): the junk is discarded in SEARCH and display begins at the next (0,0) with locked = 1.
4. Stall si_valid for 100 pixels mid-frame (FIFO drains): underflow pulses once, rgb = 0, locked = 0; relock at the next sof/(0,0).
5. Hold si_valid = 1 while the FIFO is full: si_ready = 0 with no overwrite; push+pop at count 15 keeps the count at 15 and si_ready = 1.
6. An early sof (frame truncated at pixel 640*100) moves the FSM to WAIT_FRAME; rgb = 0 until (0,0); then the new frame displays correctly.
